// File: rtl/u109_pci_read_buffer.sv
// ----------------------------------------------------------------------------
// u109_pci_read_buffer
//
// Read-direction data path of the U109 CPU/PCI data buffer. Longwords returned
// on the PCI AD bus during read data phases are captured into a small FIFO and
// presented first-word-fall-through to the 68040 D bus. The CPU-side sequencer
// pops entries with a one-cycle RDSTB pulse. Single clock domain (PCICLK).
//
// Build option:
//   U109_BYTE_SWAP_EN  When defined, each pushed word is stored byte-swapped
//                      (little-endian PCI to big-endian 68040). WIDTH must be
//                      32 in that build. When undefined, AD_IN is stored as-is.
//
// Ports:
//   PCICLK    in   PCI clock, all logic on the rising edge
//   nRESET    in   asynchronous active-low reset
//   AD_IN     in   sampled PCI AD bus
//   PCIDIR    in   0 = PCI-to-CPU (read), 1 = CPU-to-PCI (write)
//   PCICYCLE  in   high while a PCI bus cycle is in progress
//   nIRDY     in   PCI initiator ready, active low
//   nTRDY     in   PCI target ready, active low
//   nBEN      in   CPU-side data buffer enable, active low
//   RDSTB     in   one-cycle pop request (already synchronised)
//   D_OUT     out  head-of-FIFO data toward the D bus
//   D_OE      out  registered D bus drive enable
//   DVALID    out  FIFO not empty
//   FULL      out  FIFO holds DEPTH entries
//   COUNT     out  current number of entries
//   OVERRUN   out  sticky: a data phase arrived while the FIFO was full
// ----------------------------------------------------------------------------
module u109_pci_read_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     PCICLK,
    input  logic                     nRESET,
    input  logic [WIDTH-1:0]         AD_IN,
    input  logic                     PCIDIR,
    input  logic                     PCICYCLE,
    input  logic                     nIRDY,
    input  logic                     nTRDY,
    input  logic                     nBEN,
    input  logic                     RDSTB,
    output logic [WIDTH-1:0]         D_OUT,
    output logic                     D_OE,
    output logic                     DVALID,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERRUN
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
        $error("u109_pci_read_buffer: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDrain   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q, count_d;
    logic                overrun_q, overrun_d;
    logic                d_oe_q;

    logic                data_phase;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [WIDTH-1:0]    push_data;

    // Word as it is written into the FIFO.
`ifdef U109_BYTE_SWAP_EN
    if (WIDTH != 32) begin : gen_width_check
        $error("u109_pci_read_buffer: U109_BYTE_SWAP_EN requires WIDTH == 32");
    end
    assign push_data = {AD_IN[7:0], AD_IN[15:8], AD_IN[23:16], AD_IN[31:24]};
`else
    assign push_data = AD_IN;
`endif

    assign data_phase = PCICYCLE && !PCIDIR && !nIRDY && !nTRDY;

    // Flags decode the registered count, so FULL blocks a push even when a
    // pop happens on the same edge.
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = RDSTB && !empty;

    // ------------------------------------------------------------------------
    // Capture state machine: next state, push decision and overrun flag.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        push      = 1'b0;
        case (state_q)
            StIdle: begin
                if (PCICYCLE && !PCIDIR) begin
                    state_d   = StCapture;
                    overrun_d = 1'b0;
                end
            end
            StCapture: begin
                if (data_phase) begin
                    if (full) begin
                        overrun_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (!PCICYCLE) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (empty) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge PCICLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            d_oe_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            d_oe_q    <= !nBEN && !PCIDIR;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage is cleared on reset so D_OUT reads zero until the first push.
    always_ff @(posedge PCICLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign D_OUT   = mem_q[rd_ptr_q];
    assign D_OE    = d_oe_q;
    assign DVALID  = !empty;
    assign FULL    = full;
    assign COUNT   = count_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_u109_pci_read_buffer.sv
module tb_u109_pci_read_buffer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int MIdle = 0;
    localparam int MCap  = 1;
    localparam int MDrn  = 2;

    logic              PCICLK;
    logic              nRESET;
    logic [WIDTH-1:0]  AD_IN;
    logic              PCIDIR;
    logic              PCICYCLE;
    logic              nIRDY;
    logic              nTRDY;
    logic              nBEN;
    logic              RDSTB;
    logic [WIDTH-1:0]  D_OUT;
    logic              D_OE;
    logic              DVALID;
    logic              FULL;
    logic [2:0]        COUNT;
    logic              OVERRUN;

    u109_pci_read_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .PCICLK   (PCICLK),
        .nRESET   (nRESET),
        .AD_IN    (AD_IN),
        .PCIDIR   (PCIDIR),
        .PCICYCLE (PCICYCLE),
        .nIRDY    (nIRDY),
        .nTRDY    (nTRDY),
        .nBEN     (nBEN),
        .RDSTB    (RDSTB),
        .D_OUT    (D_OUT),
        .D_OE     (D_OE),
        .DVALID   (DVALID),
        .FULL     (FULL),
        .COUNT    (COUNT),
        .OVERRUN  (OVERRUN)
    );

    initial begin
        PCICLK = 1'b0;
        forever #5 PCICLK = ~PCICLK;
    end

    // Reference model state and scoreboard.
    logic [31:0] exp_q[$];
    int          mdl_mode;
    int          mdl_count;
    bit          mdl_ovr;
    bit          mdl_doe;
    int          rd_idx;
    int          n_checks;
    int          n_errors;

    function automatic logic [31:0] expect_word(input logic [31:0] w);
`ifdef U109_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Behavioural model: evaluated on each clock edge from the pre-edge inputs.
    initial begin
        mdl_mode  = MIdle;
        mdl_count = 0;
        mdl_ovr   = 0;
        mdl_doe   = 0;
        forever begin
            @(posedge PCICLK or negedge nRESET);
            if (!nRESET) begin
                mdl_mode  = MIdle;
                mdl_count = 0;
                mdl_ovr   = 0;
                mdl_doe   = 0;
            end else begin
                bit is_dp;
                bit pushed;
                bit popped;
                is_dp  = PCICYCLE && !PCIDIR && !nIRDY && !nTRDY;
                popped = RDSTB && (mdl_count > 0);
                pushed = 0;
                case (mdl_mode)
                    MIdle: begin
                        if (PCICYCLE && !PCIDIR) begin
                            mdl_mode = MCap;
                            mdl_ovr  = 0;
                        end
                    end
                    MCap: begin
                        if (is_dp) begin
                            if (mdl_count == DEPTH) mdl_ovr = 1;
                            else pushed = 1;
                        end
                        if (!PCICYCLE) mdl_mode = MDrn;
                    end
                    default: begin
                        if (mdl_count == 0) mdl_mode = MIdle;
                    end
                endcase
                if (pushed) exp_q.push_back(expect_word(AD_IN));
                mdl_count = mdl_count + (pushed ? 1 : 0) - (popped ? 1 : 0);
                mdl_doe   = !nBEN && !PCIDIR;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares outputs against the model on every falling edge and
    // consumes scoreboard entries as the sequencer pops them.
    initial begin
        n_checks = 0;
        n_errors = 0;
        rd_idx   = 0;
        forever begin
            @(negedge PCICLK or negedge nRESET);
            if (!nRESET) begin
                #1;
                chk("rst_count",   32'(COUNT), 32'd0);
                chk("rst_dvalid",  32'(DVALID), 32'd0);
                chk("rst_d_oe",    32'(D_OE), 32'd0);
                chk("rst_full",    32'(FULL), 32'd0);
                chk("rst_overrun", 32'(OVERRUN), 32'd0);
                chk("rst_d_out",   D_OUT, 32'd0);
                rd_idx = exp_q.size();
            end else begin
                chk("count",   32'(COUNT), 32'(mdl_count));
                chk("dvalid",  32'(DVALID), 32'(mdl_count != 0));
                chk("full",    32'(FULL), 32'(mdl_count == DEPTH));
                chk("overrun", 32'(OVERRUN), 32'(mdl_ovr));
                chk("d_oe",    32'(D_OE), 32'(mdl_doe));
                if (mdl_count > 0) begin
                    if (rd_idx < exp_q.size()) begin
                        chk("d_out", D_OUT, exp_q[rd_idx]);
                    end else begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard at %0t: no expected word, d_out %h",
                                 $time, D_OUT);
                    end
                    if (RDSTB) rd_idx++;
                end
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge PCICLK);
        #1;
    endtask

    task automatic idle_inputs();
        PCICYCLE = 1'b0;
        PCIDIR   = 1'b0;
        nIRDY    = 1'b1;
        nTRDY    = 1'b1;
        RDSTB    = 1'b0;
        nBEN     = 1'b0;
        AD_IN    = '0;
    endtask

    task automatic start_cycle();
        PCICYCLE = 1'b1;
        PCIDIR   = 1'b0;
        nIRDY    = 1'b1;
        nTRDY    = 1'b1;
        step();
    endtask

    task automatic do_dp(input logic [31:0] w);
        PCICYCLE = 1'b1;
        PCIDIR   = 1'b0;
        nIRDY    = 1'b0;
        nTRDY    = 1'b0;
        AD_IN    = w;
        step();
    endtask

    task automatic end_and_drain();
        PCICYCLE = 1'b0;
        PCIDIR   = 1'b0;
        nIRDY    = 1'b1;
        nTRDY    = 1'b1;
        RDSTB    = 1'b1;
        repeat (DEPTH + 3) step();
        RDSTB = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        nRESET = 1'b0;
        idle_inputs();
        repeat (3) @(posedge PCICLK);
        #1 nRESET = 1'b1;
        step();

        // Line burst then four pops.
        start_cycle();
        do_dp(32'h11110000);
        do_dp(32'h22221111);
        do_dp(32'h33332222);
        do_dp(32'h44443333);
        PCICYCLE = 1'b0;
        nIRDY    = 1'b1;
        nTRDY    = 1'b1;
        step();
        RDSTB = 1'b1;
        repeat (4) step();
        RDSTB = 1'b0;
        repeat (2) step();

        // Target wait states between data phases.
        start_cycle();
        do_dp(32'hA0A0A0A0);
        nTRDY = 1'b1;
        repeat (2) step();
        do_dp(32'hB1B1B1B1);
        end_and_drain();

        // Overrun: five data phases without a pop; flag held through drain.
        start_cycle();
        for (int i = 0; i < 5; i++) do_dp(32'hC0000000 + 32'(i));
        end_and_drain();
        start_cycle();
        end_and_drain();

        // Simultaneous push and pop at two entries, then pop while empty.
        start_cycle();
        do_dp(32'hD0000001);
        do_dp(32'hD0000002);
        RDSTB = 1'b1;
        do_dp(32'hD0000003);
        RDSTB = 1'b0;
        end_and_drain();
        idle_inputs();
        RDSTB = 1'b1;
        repeat (3) step();
        RDSTB = 1'b0;

        // Byte order of a single word.
        start_cycle();
        do_dp(32'h12345678);
        end_and_drain();

        // Randomised traffic.
        idle_inputs();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) PCICYCLE = ~PCICYCLE;
            PCIDIR = ($urandom_range(0, 9) == 0);
            nIRDY  = ($urandom_range(0, 3) == 0);
            nTRDY  = ($urandom_range(0, 2) == 0);
            RDSTB  = ($urandom_range(0, 2) == 0);
            nBEN   = ($urandom_range(0, 5) == 0);
            AD_IN  = $urandom;
            step();
        end
        idle_inputs();
        end_and_drain();
        end_and_drain();

        // Asynchronous reset after two pushes.
        start_cycle();
        do_dp(32'hE0000001);
        do_dp(32'hE0000002);
        nIRDY = 1'b1;
        nTRDY = 1'b1;
        #3 nRESET = 1'b0;
        #12;
        @(posedge PCICLK);
        #1 nRESET = 1'b1;
        idle_inputs();
        step();
        start_cycle();
        do_dp(32'hF0000001);
        end_and_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
